muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit with architectural HI/LO registers for the MIPS core.
//  Sits beside the main ALU. Decodes R-type funct codes mult/multu/div/divu/mthi/mtlo.
//  Runs one radix-2 step per cycle. hi/lo feed the mfhi/mflo writeback path.
//  The control path stalls the pipeline while busy=1.
// PARAMETERS
//  WIDTH   32   operand/HI/LO width in bits; any even value >= 4
//  CNTW    $clog2(WIDTH)+1   iteration counter width (derived; do not override)
// PORTS
//  clk     in   1      rising-edge clock; only clock in the block
//  reset   in   1      synchronous, active-high reset
//  start   in   1      launch request; sampled only when busy=0
//  funct   in   6      op select, sampled with start
//  a       in   WIDTH  rs operand (multiplicand / dividend / mthi-mtlo data)
//  b       in   WIDTH  rt operand (multiplier / divisor)
//  busy    out  1      operation in flight; new start ignored
//  done    out  1      one-cycle pulse: hi/lo hold a new mult/div result
//  hi      out  WIDTH  HI register (product high half / remainder)
//  lo      out  WIDTH  LO register (product low half / quotient)
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0. Reset wins over start.
//  Reset mid-operation aborts the operation immediately, and the result is discarded.
//  funct map: 011000 mult, 011001 multu, 011010 div, 011011 divu, 010001 mthi, 010011 mtlo.
//  Any other funct with start=1 is ignored: no state change, no done.
//  mthi/mtlo: with start=1 and busy=0 at edge k, hi (or lo) <= a at edge k. No busy, no done.
//  FSM states IDLE -> RUN -> FIX -> IDLE.
//   IDLE, start & mult/div op at edge k: latch |a|, |b| (abs only for signed ops) and the result signs.
//    Set counter=0 and go to RUN. busy=1 from cycle k+1.
//   RUN: one shift-add (mult) or restoring shift-subtract (div) step per edge.
//    Multiply uses a 2*WIDTH accumulator. Divide uses a WIDTH+1 partial remainder.
//    After WIDTH steps (edge k+WIDTH), go to FIX.
//   FIX (edge k+WIDTH+1): apply sign correction, write hi/lo, set done=1, go to IDLE.
//  Timing: busy=1 for exactly WIDTH+1 cycles. done=1 in cycle k+WIDTH+2, with busy=0.
//   A new start in the done cycle is accepted.
//  done is registered, lasts one cycle, and is never asserted for mthi/mtlo or ignored starts.
//  hi/lo hold their old values for the whole operation; they change only at FIX or on mthi/mtlo.
//  start while busy=1 is ignored: operands, funct and state are unaffected.
//  Sign rules:
//   mult: {hi,lo} = two's-complement product; negated if sign(a)^sign(b).
//   div: lo = quotient truncated toward zero, negative if sign(a)^sign(b).
//    hi = remainder, which takes the sign of a.
//  Divide by zero (b==0, div or divu): skip sign fix. lo = all ones, hi = a unchanged.
//   Latency is unchanged.
//  Signed overflow (a=-2^(WIDTH-1), b=-1): lo=a, i.e. 0x80000000 at WIDTH=32; hi=0. No trap.
//  All arithmetic wraps modulo 2^WIDTH per register. No X on outputs after reset.
// TESTING
//  T1 WIDTH=32: mult a=-3 (0xFFFFFFFD), b=5 -> done exactly 34 cycles after the start edge.
//     Result hi=0xFFFFFFFF, lo=0xFFFFFFF1. busy high for 33 cycles.
//  T2 multu a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
//     Then mult with the same operands -> hi=0, lo=1.
//  T3 div a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
//     divu a=7, b=2 -> lo=3, hi=1.
//  T4 divu a=7, b=0 -> lo=0xFFFFFFFF, hi=7.
//     div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
//  T5 start mult, then pulse start (divu) in cycle 5 while busy.
//     -> the second start is ignored and only the mult result is written.
//     Next, mtlo a=0x1234 in the done cycle -> lo=0x1234 one edge later, no extra done.
//  T6 assert reset in cycle 10 of a div -> next cycle busy=0, done=0, hi=lo=0.
//     No done pulse follows. funct=100000 with start -> no activity.

Source files
------------

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative multiply/divide unit holding the architectural
//                HI/LO registers. Decodes the R-type funct codes
//                mult/multu/div/divu/mthi/mtlo. One radix-2 step per cycle:
//                shift-add for multiply, restoring shift-subtract for divide.
//  Ports       : clk    - rising-edge clock
//                reset  - synchronous active-high reset
//                start  - launch request, honoured only while busy=0
//                funct  - operation select, sampled with start
//                a      - rs operand (multiplicand / dividend / mthi-mtlo data)
//                b      - rt operand (multiplier / divisor)
//                busy   - operation in flight; new starts are ignored
//                done   - one-cycle pulse when hi/lo hold a new mult/div result
//                hi     - HI register (product high half / remainder)
//                lo     - LO register (product low half / quotient)
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNTW  = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [5:0]      c_F_MULT  = 6'b011000;
    localparam logic [5:0]      c_F_MULTU = 6'b011001;
    localparam logic [5:0]      c_F_DIV   = 6'b011010;
    localparam logic [5:0]      c_F_DIVU  = 6'b011011;
    localparam logic [5:0]      c_F_MTHI  = 6'b010001;
    localparam logic [5:0]      c_F_MTLO  = 6'b010011;
    localparam logic [CNTW-1:0] c_LAST    = CNTW'(WIDTH - 1);
    localparam logic [CNTW-1:0] c_ONE     = CNTW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [CNTW-1:0]    r_cnt;
    logic               r_is_div;
    logic               r_neg_res;   // negate product / quotient at FIX
    logic               r_neg_rem;   // negate remainder at FIX (sign of dividend)
    logic               r_divz;      // divisor was zero
    logic [WIDTH-1:0]   r_opb;       // |multiplicand| or |divisor|
    // Multiply: full 2*WIDTH accumulator, multiplier shifts out of the low end.
    // Divide: low half holds the dividend, quotient bits shift in from the right.
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_rem;       // partial remainder, always < divisor

    // ------------------------------------------------------------------
    // Launch decode
    // ------------------------------------------------------------------
    logic             w_is_mul;
    logic             w_is_div;
    logic             w_signed;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;

    assign w_is_mul = (funct == c_F_MULT) || (funct == c_F_MULTU);
    assign w_is_div = (funct == c_F_DIV)  || (funct == c_F_DIVU);
    assign w_signed = (funct == c_F_MULT) || (funct == c_F_DIV);
    // The most negative value maps onto itself, which read as unsigned is
    // exactly its magnitude, so no special case is needed here.
    assign w_abs_a  = (w_signed && a[WIDTH-1]) ? (-a) : a;
    assign w_abs_b  = (w_signed && b[WIDTH-1]) ? (-b) : b;

    // ------------------------------------------------------------------
    // Multiply step: add multiplicand into the high half when the current
    // multiplier bit is set, then shift right keeping the carry.
    // ------------------------------------------------------------------
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_mul_next;

    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opb};
    assign w_mul_next = r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]}
                                 : {1'b0, r_acc[2*WIDTH-1:1]};

    // ------------------------------------------------------------------
    // Divide step: shift next dividend bit into the remainder (WIDTH+1
    // bits wide), trial-subtract the divisor, keep the difference only
    // if it did not borrow.
    // ------------------------------------------------------------------
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_qbit;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;

    assign w_shift    = {r_rem, r_acc[WIDTH-1]};
    assign w_trial    = w_shift - {1'b0, r_opb};
    assign w_qbit     = ~w_trial[WIDTH];
    assign w_rem_next = w_qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_next = {r_acc[WIDTH-2:0], w_qbit};

    // ------------------------------------------------------------------
    // Sign correction applied in FIX
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_prod_fix = r_neg_res ? (-r_acc) : r_acc;
    assign w_quo_fix  = r_neg_res ? (-r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
    // With a zero divisor the remainder register ends up holding |a|, so the
    // same correction hands back the original dividend.
    assign w_rem_fix  = r_neg_rem ? (-r_rem) : r_rem;

    // ------------------------------------------------------------------
    // Control FSM and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_divz    <= 1'b0;
            r_opb     <= '0;
            r_acc     <= '0;
            r_rem     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_is_mul || w_is_div) begin
                            r_state   <= S_RUN;
                            r_busy    <= 1'b1;
                            r_cnt     <= '0;
                            r_is_div  <= w_is_div;
                            r_neg_res <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                            r_neg_rem <= w_signed && a[WIDTH-1];
                            r_divz    <= w_is_div && (b == '0);
                            r_opb     <= w_is_mul ? w_abs_a : w_abs_b;
                            r_acc     <= {{WIDTH{1'b0}}, (w_is_mul ? w_abs_b : w_abs_a)};
                            r_rem     <= '0;
                        end else if (funct == c_F_MTHI) begin
                            r_hi <= a;
                        end else if (funct == c_F_MTLO) begin
                            r_lo <= a;
                        end
                    end
                end
                S_RUN: begin
                    if (r_is_div) begin
                        r_acc[WIDTH-1:0] <= w_quo_next;
                        r_rem            <= w_rem_next;
                    end else begin
                        r_acc <= w_mul_next;
                    end
                    r_cnt <= r_cnt + c_ONE;
                    if (r_cnt == c_LAST) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (r_is_div) begin
                        r_hi <= w_rem_fix;
                        r_lo <= r_divz ? {WIDTH{1'b1}} : w_quo_fix;
                    end else begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_unit
//  Description : Self-checking bench for muldiv_unit (WIDTH=32). Directed
//                corner cases plus randomized operations compared against an
//                arithmetic reference model of HI/LO.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    localparam int W = 32;

    localparam logic [5:0] c_F_MULT  = 6'b011000;
    localparam logic [5:0] c_F_MULTU = 6'b011001;
    localparam logic [5:0] c_F_DIV   = 6'b011010;
    localparam logic [5:0] c_F_DIVU  = 6'b011011;
    localparam logic [5:0] c_F_MTHI  = 6'b010001;
    localparam logic [5:0] c_F_MTLO  = 6'b010011;

    logic         clk;
    logic         reset;
    logic         start;
    logic [5:0]   funct;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_compared;
    int n_mismatched;

    logic [W-1:0] hi_m;
    logic [W-1:0] lo_m;

    muldiv_unit #(.WIDTH(W)) u_dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .funct (funct),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] ref_muldiv(input logic [5:0] f, input logic [W-1:0] x,
                                               input logic [W-1:0] y);
        longint sx;
        longint sy;
        longint q;
        longint m;
        logic [63:0] r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r  = '0;
        case (f)
            c_F_MULT:  r = sx * sy;
            c_F_MULTU: r = {32'b0, x} * {32'b0, y};
            c_F_DIV: begin
                if (y == '0) begin
                    r = {x, 32'hFFFF_FFFF};
                end else begin
                    q = sx / sy;   // truncates toward zero
                    m = sx % sy;   // sign of dividend
                    r = {m[31:0], q[31:0]};
                end
            end
            c_F_DIVU: begin
                if (y == '0) r = {x, 32'hFFFF_FFFF};
                else         r = {x % y, x / y};
            end
            default: r = {hi_m, lo_m};
        endcase
        return r;
    endfunction

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            4:       return -32'($urandom_range(1, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    // Called at a falling edge. Launches a mult/div op, optionally pulses an
    // ignored divu start in cycle ign_at, and returns at the falling edge of
    // the done cycle after checking timing and the result.
    task automatic run_op(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y,
                          input int ign_at);
        logic [63:0] e;
        int ncyc;
        int nbusy;
        e = ref_muldiv(f, x, y);
        start = 1'b1; funct = f; a = x; b = y;
        @(negedge clk);
        start = 1'b0; funct = 6'($urandom); a = 32'($urandom); b = 32'($urandom);
        ncyc  = 1;
        nbusy = 0;
        while (done !== 1'b1 && ncyc < 60) begin
            if (busy === 1'b1) nbusy++;
            if (ncyc == 10) check_eq("hilo_hold", {hi, lo}, {hi_m, lo_m});
            if (ncyc == ign_at) begin
                start = 1'b1; funct = c_F_DIVU; a = 32'($urandom); b = 32'($urandom_range(1, 9));
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            ncyc++;
        end
        start = 1'b0;
        check_eq("latency", 64'(ncyc), 64'(W + 2));
        check_eq("busy_cycles", 64'(nbusy), 64'(W + 1));
        check_eq("busy_at_done", 64'(busy), 64'd0);
        check_eq("result", {hi, lo}, e);
        hi_m = e[63:32];
        lo_m = e[31:0];
    endtask

    task automatic done_ends();
        @(negedge clk);
        check_eq("done_pulse", 64'(done), 64'd0);
    endtask

    task automatic mt_op(input logic [5:0] f, input logic [W-1:0] x);
        start = 1'b1; funct = f; a = x;
        @(negedge clk);
        start = 1'b0;
        if (f == c_F_MTHI) hi_m = x;
        else               lo_m = x;
        check_eq("mt_hilo", {hi, lo}, {hi_m, lo_m});
        check_eq("mt_no_busy_done", {62'd0, busy, done}, 64'd0);
    endtask

    task automatic bad_op(input logic [5:0] f);
        start = 1'b1; funct = f; a = 32'($urandom); b = 32'($urandom);
        @(negedge clk);
        start = 1'b0;
        check_eq("bad_no_busy_done", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        check_eq("bad_hilo", {61'd0, busy, done, 1'b0} | {hi, lo} ^ {hi_m, lo_m}, 64'd0);
    endtask

    function automatic logic [5:0] rand_bad_funct();
        logic [5:0] f;
        f = 6'($urandom);
        while (f == c_F_MULT || f == c_F_MULTU || f == c_F_DIV || f == c_F_DIVU ||
               f == c_F_MTHI || f == c_F_MTLO) f = 6'($urandom);
        return f;
    endfunction

    initial begin
        int ncyc;
        int seen;
        logic [5:0] f;
        n_compared   = 0;
        n_mismatched = 0;
        hi_m = '0;
        lo_m = '0;
        reset = 1'b1; start = 1'b1; funct = c_F_MTHI; a = 32'hDEAD_BEEF; b = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_state", {hi, lo}, 64'd0);
        check_eq("reset_flags", {62'd0, busy, done}, 64'd0);
        reset = 1'b0; start = 1'b0;
        @(negedge clk);

        // T1
        run_op(c_F_MULT, 32'hFFFF_FFFD, 32'd5, 0);
        check_eq("t1_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        done_ends();
        // T2
        run_op(c_F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check_eq("t2_multu", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        done_ends();
        run_op(c_F_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check_eq("t2_mult", {hi, lo}, 64'h0000_0000_0000_0001);
        done_ends();
        // T3
        run_op(c_F_DIV, -32'd7, 32'd2, 0);
        check_eq("t3_div", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        done_ends();
        run_op(c_F_DIVU, 32'd7, 32'd2, 0);
        check_eq("t3_divu", {hi, lo}, 64'h0000_0001_0000_0003);
        done_ends();
        // T4
        run_op(c_F_DIVU, 32'd7, 32'd0, 0);
        check_eq("t4_divz", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
        done_ends();
        run_op(c_F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check_eq("t4_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
        done_ends();
        run_op(c_F_DIV, -32'd9, 32'd0, 0);
        check_eq("t4_sdivz", {hi, lo}, {-32'd9, 32'hFFFF_FFFF});
        done_ends();
        // T5: ignored start while busy, then mtlo in the done cycle
        run_op(c_F_MULT, 32'd1234567, -32'd89, 5);
        mt_op(c_F_MTLO, 32'h0000_1234);
        check_eq("t5_mtlo", {32'd0, lo}, 64'h0000_0000_0000_1234);
        mt_op(c_F_MTHI, 32'hCAFE_F00D);

        // T6: reset in cycle 10 of a divide
        start = 1'b1; funct = c_F_DIV; a = -32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        ncyc = 1;
        while (ncyc < 10) begin
            @(negedge clk);
            ncyc++;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        hi_m = '0;
        lo_m = '0;
        check_eq("t6_reset_flags", {62'd0, busy, done}, 64'd0);
        check_eq("t6_reset_hilo", {hi, lo}, 64'd0);
        seen = 0;
        repeat (W + 6) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        check_eq("t6_no_done", 64'(seen), 64'd0);
        bad_op(6'b100000);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 7))
                0: f = c_F_MULT;
                1: f = c_F_MULTU;
                2: f = c_F_DIV;
                3: f = c_F_DIVU;
                4: f = c_F_MTHI;
                5: f = c_F_MTLO;
                default: f = rand_bad_funct();
            endcase
            if (f == c_F_MTHI || f == c_F_MTLO) begin
                mt_op(f, rand_operand());
            end else if (f == c_F_MULT || f == c_F_MULTU || f == c_F_DIV || f == c_F_DIVU) begin
                run_op(f, rand_operand(), rand_operand(), (i % 3 == 0) ? 7 : 0);
                done_ends();
            end else begin
                bad_op(f);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire
